// File: rtl/seq_pattern_gen_pkg.sv
// seq_pattern_gen_pkg: shared types and pattern lookup for the serial pattern generator.
//   pat_id_e  : pattern ids (0=1101, 1=1010, 2=1001, 3=0110)
//   gen_state : generator FSM states
//   pattern() : 4-bit pattern for a pattern id, MSB sent first
package seq_pattern_gen_pkg;
  localparam int PAT_W = 4;
  typedef enum logic [1:0] {P1101, P1010, P1001, P0110} pat_id_e;
  typedef enum logic [1:0] {IDLE, SHIFT, GAP, DONE} gen_state;
  function automatic logic [PAT_W-1:0] pattern(input pat_id_e id);
    return id == P1101 ? 4'b1101 : id == P1010 ? 4'b1010 : id == P1001 ? 4'b1001 : 4'b0110;
  endfunction
endpackage

// File: rtl/seq_pattern_gen_piso.sv
// seq_piso4: 4-bit parallel-load shift-left register, load has priority over shift.
//   clock_i, areset_ni : clock, async active-low reset
//   load_i, d_i        : parallel load of d_i
//   shift_i            : shift left, zero fill
//   msb_o              : bit 3 of the register
module seq_piso4 import seq_pattern_gen_pkg::*; (
  input  logic             clock_i,
  input  logic             areset_ni,
  input  logic             load_i,
  input  logic             shift_i,
  input  logic [PAT_W-1:0] d_i,
  output logic             msb_o
);
  logic [PAT_W-1:0] shreg_q, shreg_d;
  always_comb shreg_d = load_i ? d_i : shift_i ? {shreg_q[PAT_W-2:0], 1'b0} : shreg_q;
  always_ff @(posedge clock_i or negedge areset_ni)
    if (!areset_ni) shreg_q <= '0;
    else shreg_q <= shreg_d;
  assign msb_o = shreg_q[PAT_W-1];
endmodule

// File: rtl/seq_pattern_gen.sv
// seq_pattern_gen: serialises a selected 4-bit pattern MSB-first, repeated req_count_i+1 times.
//   clock_i, areset_ni         : clock, async active-low reset
//   req_valid_i/req_ready_o    : request handshake (ready only in IDLE)
//   req_sel_i, req_count_i     : pattern id, repetitions minus one
//   out_o, out_valid_o         : serial bit and its qualifier
//   busy_o, done_o             : not-idle flag, end-of-transfer pulse
//   Define SEQGEN_GAP_EN to insert GAP_CYCLES idle cycles between repetitions.
module seq_pattern_gen import seq_pattern_gen_pkg::*; #(
  parameter int CNT_W      = 4,
  parameter int GAP_CYCLES = 2
) (
  input  logic             clock_i,
  input  logic             areset_ni,
  input  logic             req_valid_i,
  input  logic [1:0]       req_sel_i,
  input  logic [CNT_W-1:0] req_count_i,
  output logic             req_ready_o,
  output logic             out_o,
  output logic             out_valid_o,
  output logic             busy_o,
  output logic             done_o
);
  gen_state         state_q, state_d;
  pat_id_e          sel_q, sel_d;
  logic [1:0]       bit_q, bit_d;
  logic [CNT_W-1:0] rep_q, rep_d;
  logic             load, shift, msb;
  logic [PAT_W-1:0] load_val;
`ifdef SEQGEN_GAP_EN
  logic [3:0]       gap_q, gap_d;
`else
  logic             unused_gap;
  assign unused_gap = GAP_CYCLES != 0;
`endif
  always_comb begin
    state_d  = state_q;
    sel_d    = sel_q;
    bit_d    = bit_q;
    rep_d    = rep_q;
    load     = 1'b0;
    shift    = 1'b0;
    load_val = pattern(sel_q);
`ifdef SEQGEN_GAP_EN
    gap_d    = gap_q;
`endif
    case (state_q)
      IDLE: if (req_valid_i) begin
        load     = 1'b1;
        load_val = pattern(pat_id_e'(req_sel_i));
        sel_d    = pat_id_e'(req_sel_i);
        bit_d    = 2'd3;
        rep_d    = req_count_i;
        state_d  = SHIFT;
      end
      SHIFT: if (bit_q != 2'd0) begin
        shift = 1'b1;
        bit_d = bit_q - 2'd1;
      end else if (rep_q != '0) begin
        // reload the captured pattern; it holds in the register across any gap
        load  = 1'b1;
        bit_d = 2'd3;
        rep_d = rep_q - CNT_W'(1);
`ifdef SEQGEN_GAP_EN
        if (GAP_CYCLES > 0) begin
          state_d = GAP;
          gap_d   = 4'(GAP_CYCLES - 1);
        end
`endif
      end else state_d = DONE;
`ifdef SEQGEN_GAP_EN
      GAP: if (gap_q == 4'd0) state_d = SHIFT;
      else gap_d = gap_q - 4'd1;
`endif
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clock_i or negedge areset_ni)
    if (!areset_ni) begin
      state_q <= IDLE;
      sel_q   <= P1101;
      bit_q   <= '0;
      rep_q   <= '0;
`ifdef SEQGEN_GAP_EN
      gap_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      bit_q   <= bit_d;
      rep_q   <= rep_d;
`ifdef SEQGEN_GAP_EN
      gap_q   <= gap_d;
`endif
    end
  seq_piso4 u_piso (
    .clock_i  (clock_i),
    .areset_ni(areset_ni),
    .load_i   (load),
    .shift_i  (shift),
    .d_i      (load_val),
    .msb_o    (msb)
  );
  // outputs decode registered state only, so no input-to-output path exists
  assign req_ready_o = state_q == IDLE;
  assign busy_o      = state_q != IDLE;
  assign out_valid_o = state_q == SHIFT;
  assign out_o       = out_valid_o & msb;
  assign done_o      = state_q == DONE;
endmodule

// File: tb/tb_seq_pattern_gen.sv
// tb_seq_pattern_gen: self-checking bench for seq_pattern_gen against a per-cycle stream model.
module tb_seq_pattern_gen;
`ifdef SEQGEN_GAP_EN
  localparam int GAPC = 2;
`else
  localparam int GAPC = 0;
`endif
  logic       clk = 1'b0;
  logic       areset_ni = 1'b0;
  logic       req_valid_i = 1'b0;
  logic [1:0] req_sel_i = '0;
  logic [3:0] req_count_i = '0;
  logic       req_ready_o, out_o, out_valid_o, busy_o, done_o;
  int         n_checks = 0;
  int         n_fail = 0;
  always #5 clk = ~clk;
  seq_pattern_gen #(.CNT_W(4), .GAP_CYCLES(2)) dut (
    .clock_i    (clk),
    .areset_ni  (areset_ni),
    .req_valid_i(req_valid_i),
    .req_sel_i  (req_sel_i),
    .req_count_i(req_count_i),
    .req_ready_o(req_ready_o),
    .out_o      (out_o),
    .out_valid_o(out_valid_o),
    .busy_o     (busy_o),
    .done_o     (done_o)
  );
  typedef struct {
    logic [1:0] sel;
    logic [3:0] cnt;
    logic [3:0] pat;
    bit         noisy;
    int         nbits;
  } vec_t;
  vec_t       tbl[5];
  logic [3:0] pat_lut[4];
  function automatic logic [4:0] obs();
    return {out_valid_o, out_o, done_o, busy_o, req_ready_o};
  endfunction
  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask
  // Expected per-cycle {valid,out,done,busy,ready} from the cycle after the handshake
  // through the cycle ready returns; optional noise on the request inputs while busy.
  task automatic run_req(input string name, input logic [1:0] sel, input logic [3:0] cnt,
                         input logic [3:0] pat, input bit noisy, input int nbits);
    logic [4:0] exp_q[$];
    logic [4:0] got;
    int nvalid = 0;
    for (int r = 0; r <= int'(cnt); r++) begin
      for (int i = 3; i >= 0; i--) exp_q.push_back({1'b1, pat[i], 1'b0, 1'b1, 1'b0});
      if (r < int'(cnt)) for (int g = 0; g < GAPC; g++) exp_q.push_back(5'b00010);
    end
    exp_q.push_back(5'b00110);
    exp_q.push_back(5'b00001);
    check({name, " ready"}, 32'(req_ready_o), 32'd1);
    req_valid_i = 1'b1;
    req_sel_i   = sel;
    req_count_i = cnt;
    @(posedge clk);
    for (int j = 0; j < exp_q.size(); j++) begin
      @(negedge clk);
      req_valid_i = 1'b0;
      got = obs();
      check(name, 32'(got), 32'(exp_q[j]));
      nvalid += int'(got[4]);
      if (noisy && j < exp_q.size() - 1) begin
        req_valid_i = 1'($urandom);
        req_sel_i   = 2'($urandom);
        req_count_i = 4'($urandom);
      end
    end
    check({name, " nbits"}, 32'(nvalid), 32'(nbits));
  endtask
  initial begin
    pat_lut = '{4'b1101, 4'b1010, 4'b1001, 4'b0110};
    tbl[0] = '{2'd0, 4'd0,  4'b1101, 1'b0, 4};
    tbl[1] = '{2'd1, 4'd2,  4'b1010, 1'b0, 12};
    tbl[2] = '{2'd3, 4'd1,  4'b0110, 1'b0, 8};
    tbl[3] = '{2'd2, 4'd15, 4'b1001, 1'b0, 64};
    tbl[4] = '{2'd1, 4'd3,  4'b1010, 1'b1, 16};
    #12;
    check("reset state", 32'(obs()), 32'(5'b00001));
    @(negedge clk);
    areset_ni = 1'b1;
    @(negedge clk);
    check("idle hold", 32'(obs()), 32'(5'b00001));
    for (int t = 0; t < 5; t++)
      run_req($sformatf("vec%0d", t), tbl[t].sel, tbl[t].cnt, tbl[t].pat, tbl[t].noisy, tbl[t].nbits);
    req_valid_i = 1'b1;
    req_sel_i   = 2'd0;
    req_count_i = 4'd3;
    @(posedge clk);
    @(negedge clk);
    req_valid_i = 1'b0;
    check("rst bit0", 32'(obs()), 32'(5'b11010));
    @(posedge clk);
    #2 areset_ni = 1'b0;
    #1 check("rst mid", 32'(obs()), 32'(5'b00001));
    @(negedge clk);
    areset_ni = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("rst no done", 32'(obs()), 32'(5'b00001));
    end
    run_req("after rst", 2'd3, 4'd0, 4'b0110, 1'b0, 4);
    for (int t = 0; t < 8; t++) begin
      logic [1:0] s;
      logic [3:0] c;
      s = 2'($urandom);
      c = 4'($urandom_range(0, 5));
      run_req($sformatf("rand%0d", t), s, c, pat_lut[s], 1'($urandom), 4 * (int'(c) + 1));
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/seq_pattern_gen.md
# seq_pattern_gen

Serial pattern generator that drives the stimulus side of the 4-pattern overlapping sequence detector link. It accepts a pattern-select request over a valid/ready handshake and serialises the selected 4-bit pattern MSB-first, one bit per clock, repeating it a requested number of times. It sits upstream of the detector, as the on-chip stimulus source and loopback transmitter.

## Interface
- CNT_W, 4: width of the repeat-count field.
- GAP_CYCLES, 2: idle cycles between repetitions. Used only when SEQGEN_GAP_EN is defined; legal range 0..15.
- clock_i  input  1  system clock; all flops on the rising edge.
- areset_ni  input  1  one clock; reset is asynchronous and active-low.
- req_valid_i  input  1  request present.
- req_sel_i  input  2  pattern id: 0=1101, 1=1010, 2=1001, 3=0110.
- req_count_i  input  CNT_W  repetitions minus one: the pattern is sent req_count_i+1 times.
- req_ready_o  output  1  high exactly when the FSM is in IDLE.
- out_o  output  1  serial data bit, MSB first.
- out_valid_o  output  1  out_o carries a pattern bit this cycle.
- busy_o  output  1  high in any state other than IDLE.
- done_o  output  1  one-cycle pulse after the last bit of the last repetition.

## Operation
- FSM states: IDLE, SHIFT, GAP, DONE. Reset state is IDLE.
- Reset values: out_o=0, out_valid_o=0, busy_o=0, done_o=0, req_ready_o=1. All outputs are decoded from flops only; there is no combinational input-to-output path.
- IDLE: when req_valid_i and req_ready_o are both high at a rising edge, the block loads the shift register with the pattern for req_sel_i, sets bit counter=3 and sets rep counter=req_count_i, then goes to SHIFT. Without a handshake it stays in IDLE.
- SHIFT: out_valid_o=1 and out_o=shreg[3]. Each cycle the register shifts left and the bit counter decrements. After bit 0:
  - If rep counter>0: decrement it and reload the same pattern. Go to GAP if the macro is enabled and GAP_CYCLES>0; otherwise stay in SHIFT, so bits go back-to-back.
  - If rep counter=0: go to DONE.
- GAP: out_valid_o=0, out_o=0 for GAP_CYCLES cycles, then return to SHIFT.
- DONE: done_o=1 for one cycle, then go to IDLE.
- req_valid_i, req_sel_i and req_count_i are ignored outside IDLE. The selection and count are captured only at the handshake edge.
- Rep counter width is CNT_W. The maximum request (all ones) gives 2^CNT_W repetitions. There is no wrap-around because the counter only decrements to 0.
- Asynchronous reset mid-operation forces IDLE immediately. Outputs take their reset values, no done_o pulse is issued, and the transfer is discarded.
- The default branch of every case returns to IDLE with outputs low.

## Timing
- Handshake at edge k: the first bit (pattern MSB) is valid in cycle k+1. Bit i of repetition r is valid in cycle k+1+4r+i, without gap.
- Without gap, the last bit is in cycle k+4(N+1), where N=req_count_i. done_o is high in the following cycle, and req_ready_o returns high in the cycle after that.
- With gap: each of the N inter-repetition boundaries adds GAP_CYCLES cycles. There is no gap after the final repetition.
- Throughput: one bit per clock while in SHIFT. A new request can be accepted one cycle after done_o.

## Configuration
- SEQGEN_GAP_EN defined: the GAP state is compiled in and GAP_CYCLES guard cycles (out_valid_o=0, out_o=0) are inserted between repetitions.
- Not defined: the GAP state and its counter are absent, GAP_CYCLES is ignored, and repetitions stream back-to-back. This exercises the detector's overlap paths.

## Structure
- Shared package constants gains:
  - the pattern-id enum (P1101, P1010, P1001, P0110);
  - the 4-bit pattern lookup function;
  - the generator state enum gen_state (IDLE, SHIFT, GAP, DONE).
- Sub-module seq_piso4: a 4-bit parallel-load, shift-left register with load/shift enables and msb output. The parent keeps the FSM and both counters.

## Test plan
- Reset release, then sel=0, count=0 -> out_o=1,1,0,1 in cycles k+1..k+4 with out_valid_o=1; done_o in k+5; req_ready_o high in k+6.
- sel=1, count=2, macro off -> 12 contiguous bits 101010101010; done_o once. In loopback, the detector output pulses on every complete 1010.
- sel=3, count=1, SEQGEN_GAP_EN with GAP_CYCLES=2 -> 0110, two cycles of out_valid_o=0 and out_o=0, then 0110, then done_o.
- req_valid_i toggled with new sel/count while busy -> ignored; the stream matches the first request and req_ready_o stays low.
- areset_ni pulsed low at the second bit of a 4-repetition transfer -> outputs go to 0 immediately with no done_o pulse; after release a new request starts cleanly.
- count=all ones (CNT_W=4), sel=2 -> exactly 64 valid bits, then done_o.
